// File: rtl/alu_sequencer.sv
// alu_sequencer: issues one ALU request at a time, waits on the modulo unit, captures the result
module alu_sequencer #(
    parameter int           WIDTH   = 32,
    parameter logic [2:0]   MOD_OP  = 3'b111,
    parameter int           TIMEOUT = 64
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [2:0]       op_sel,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    output logic             mod_start,
    input  logic [WIDTH-1:0] alu_res,
    input  logic             alu_cout,
    input  logic             mod_done,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             cout_q,
    output logic             done,
    output logic             timeout_err
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_MOD, CAPTURE} state_t;
    state_t     state_q;
    logic [7:0] cnt_q;
    assign busy = state_q != IDLE;
    // Request FSM; result, carry and done are loaded on entry to CAPTURE so they are valid during it
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_op      <= '0;
            mod_start   <= 1'b0;
            result      <= '0;
            cout_q      <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            mod_start <= 1'b0;
            done      <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    alu_a       <= op_a;
                    alu_b       <= op_b;
                    alu_op      <= op_sel;
                    mod_start   <= op_sel == MOD_OP;
                    timeout_err <= 1'b0;
                    state_q     <= ISSUE;
                end
                ISSUE: if (alu_op == MOD_OP) begin
                    cnt_q   <= '0;
                    state_q <= WAIT_MOD;
                end else begin
                    result  <= alu_res;
                    cout_q  <= alu_cout;
                    done    <= 1'b1;
                    state_q <= CAPTURE;
                end
                WAIT_MOD: begin
                    cnt_q <= cnt_q + 8'd1;
                    if (mod_done) begin
                        result  <= alu_res;
                        cout_q  <= 1'b0;
                        done    <= 1'b1;
                        state_q <= CAPTURE;
                    end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                        result      <= '0;
                        cout_q      <= 1'b0;
                        timeout_err <= 1'b1;
                        done        <= 1'b1;
                        state_q     <= CAPTURE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed vectors with a done-driven scoreboard
module tb_alu_sequencer;
    localparam int TO = 64;
    localparam logic [2:0] MOD = 3'b111;

    logic        CLK = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] op_a = '0, op_b = '0;
    logic [2:0]  op_sel = '0;
    logic [31:0] alu_a, alu_b;
    logic [2:0]  alu_op;
    logic        mod_start;
    logic [31:0] alu_res = '0;
    logic        alu_cout = 1'b0;
    logic        mod_done = 1'b0;
    logic        busy;
    logic [31:0] result;
    logic        cout_q, done, timeout_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] res;
        logic        co;
        logic        terr;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    alu_sequencer #(.WIDTH(32), .MOD_OP(MOD), .TIMEOUT(TO)) dut (
        .CLK(CLK), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b), .op_sel(op_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .mod_start(mod_start),
        .alu_res(alu_res), .alu_cout(alu_cout), .mod_done(mod_done), .busy(busy),
        .result(result), .cout_q(cout_q), .done(done), .timeout_err(timeout_err)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // monitor: every done pulse is matched against the oldest expected response
    always @(negedge CLK) begin
        if (done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", result, e.res);
                chk("cout_q", 32'(cout_q), 32'(e.co));
                chk("timeout_err", 32'(timeout_err), 32'(e.terr));
                chk("done_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] sel,
                          input logic [31:0] res, input logic co, input int k, input logic coll,
                          input logic [31:0] eres, input logic eco, input logic eterr, input int lat);
        int c, ms, nms;
        logic fin;
        @(negedge CLK);
        op_a = a; op_b = b; op_sel = sel; alu_res = res; alu_cout = co; start = 1'b1;
        c = cyc;
        sb.push_back('{eres, eco, eterr, c + lat});
        ms = -1000; nms = 0; fin = 1'b0;
        for (int i = 0; i < 300 && !fin; i++) begin
            @(negedge CLK);
            start = 1'b0;
            if (coll && cyc == c + 4) begin
                start = 1'b1; op_a = ~a; op_b = ~b; op_sel = 3'b000;
            end
            if (mod_start) begin nms++; ms = cyc; end
            if (k > 0 && ms >= 0 && cyc == ms + k) mod_done = 1'b1;
            fin = !busy;
        end
        mod_done = 1'b0;
        chk("request_completes", 32'(fin), 32'd1);
        chk("mod_start_pulses", nms, (sel == MOD) ? 32'd1 : 32'd0);
        chk("alu_a_held", alu_a, a);
        chk("alu_b_held", alu_b, b);
        chk("alu_op_held", 32'(alu_op), 32'(sel));
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got no finish expected finish before 2ms");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge CLK);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_mod_start", 32'(mod_start), 0);
        chk("rst_result", result, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_terr", 32'(timeout_err), 0);
        reset = 1'b1;
        run_op(32'd5, 32'd7, 3'b000, 32'd12, 1'b0, 0, 1'b0, 32'd12, 1'b0, 1'b0, 2);
        run_op(32'hFFFFFFFF, 32'd1, 3'b000, 32'd0, 1'b1, 0, 1'b0, 32'd0, 1'b1, 1'b0, 2);
        run_op(32'd10, 32'd3, 3'b001, 32'd7, 1'b0, 0, 1'b0, 32'd7, 1'b0, 1'b0, 2);
        run_op(32'd17, 32'd7, MOD, 32'd3, 1'b1, 5, 1'b0, 32'd3, 1'b0, 1'b0, 7);
        run_op(32'd20, 32'd6, MOD, 32'd2, 1'b0, 5, 1'b1, 32'd2, 1'b0, 1'b0, 7);
        run_op(32'd9, 32'd4, MOD, 32'd1, 1'b0, 1, 1'b0, 32'd1, 1'b0, 1'b0, 3);
        run_op(32'd8, 32'd3, MOD, 32'd2, 1'b0, TO - 1, 1'b0, 32'd2, 1'b0, 1'b0, TO + 1);
        run_op(32'd100, 32'd7, MOD, 32'd2, 1'b1, -1, 1'b0, 32'd0, 1'b0, 1'b1, TO + 2);
        chk("terr_holds", 32'(timeout_err), 1);
        mod_done = 1'b1;
        run_op(32'd1, 32'd2, 3'b000, 32'd3, 1'b0, 0, 1'b0, 32'd3, 1'b0, 1'b0, 2);
        @(negedge CLK);
        op_a = 32'd50; op_b = 32'd9; op_sel = MOD; alu_res = 32'd5; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (5) @(negedge CLK);
        chk("pre_rst_busy", 32'(busy), 1);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_done", 32'(done), 0);
        chk("mid_rst_mod_start", 32'(mod_start), 0);
        chk("mid_rst_result", result, 0);
        chk("mid_rst_cout", 32'(cout_q), 0);
        chk("mid_rst_terr", 32'(timeout_err), 0);
        chk("mid_rst_alu_a", alu_a, 0);
        chk("mid_rst_alu_b", alu_b, 0);
        chk("mid_rst_alu_op", 32'(alu_op), 0);
        repeat (3) @(negedge CLK);
        reset = 1'b1;
        run_op(32'd2, 32'd2, 3'b000, 32'd4, 1'b0, 0, 1'b0, 32'd4, 1'b0, 1'b0, 2);
        repeat (3) @(negedge CLK);
        chk("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
